// File: rtl/vending_machine.sv
// Ticket vending machine for a 7-station line: fare, amount due and coin accumulation.
// Optional `change` output is enabled by defining VM_CHANGE_EN.
module vending_machine (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] howManyTicket,
  input  logic [2:0] origin,
  input  logic [2:0] destination,
  input  logic [5:0] money,
  output logic [6:0] costOfTicket,
  output logic [6:0] moneyToPay,
  output logic [6:0] totalMoney
`ifdef VM_CHANGE_EN
  ,
  output logic [6:0] change
`endif
);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    QTY    = 2'd1,
    PAY    = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cost_q, cost_d;
  logic [6:0] due_q, due_d;
  logic [6:0] total_q, total_d;
  logic [6:0] change_q, change_d;

  logic [2:0] dist_s;
  logic       trip_ok_s;
  logic [6:0] coin_s;

  // Only 1, 5 and 10 are recognised coins; anything else is worth nothing.
  function automatic logic [6:0] coin_value(input logic [5:0] m);
    logic [6:0] v;
    case (m)
      6'd1:    v = 7'd1;
      6'd5:    v = 7'd5;
      6'd10:   v = 7'd10;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  assign trip_ok_s = (origin != 3'd0) && (destination != 3'd0) && (origin != destination);
  assign dist_s    = (origin >= destination) ? (origin - destination) : (destination - origin);
  assign coin_s    = coin_value(money);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SELECT;
      cost_q   <= 7'd0;
      due_q    <= 7'd0;
      total_q  <= 7'd0;
      change_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      cost_q   <= cost_d;
      due_q    <= due_d;
      total_q  <= total_d;
      change_q <= change_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    due_d    = due_q;
    total_d  = total_q;
    change_d = change_q;
    case (state_q)
      SELECT: begin
        if (trip_ok_s) begin
          cost_d  = ({4'd0, dist_s} + 7'd1) * 7'd5;
          state_d = QTY;
        end else begin
          state_d = SELECT;
        end
      end
      QTY: begin
        // Count is at most 3, so the product fits in 7 bits (max 105).
        case (howManyTicket)
          3'd1: begin
            due_d   = cost_q;
            state_d = PAY;
          end
          3'd2: begin
            due_d   = {cost_q[5:0], 1'b0};
            state_d = PAY;
          end
          3'd3: begin
            due_d   = cost_q + {cost_q[5:0], 1'b0};
            state_d = PAY;
          end
          default: state_d = QTY;
        endcase
      end
      PAY: begin
        total_d = total_q + coin_s;
        if (total_d >= due_q) begin
          change_d = total_d - due_q;
          state_d  = DONE;
        end else begin
          state_d = PAY;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = SELECT;
      end
    endcase
  end

  assign costOfTicket = cost_q;
  assign moneyToPay   = due_q;
  assign totalMoney   = total_q;
`ifdef VM_CHANGE_EN
  assign change       = change_q;
`else
  logic unused_change_s;
  assign unused_change_s = ^change_q;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine (covers VM_CHANGE_EN when defined).
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic [2:0] howManyTicket;
  logic [2:0] origin;
  logic [2:0] destination;
  logic [5:0] money;
  logic [6:0] costOfTicket;
  logic [6:0] moneyToPay;
  logic [6:0] totalMoney;
`ifdef VM_CHANGE_EN
  logic [6:0] change;
`endif

  int errors = 0;
  int checks = 0;

  vending_machine dut (
    .clk           (clk),
    .reset         (reset),
    .howManyTicket (howManyTicket),
    .origin        (origin),
    .destination   (destination),
    .money         (money),
    .costOfTicket  (costOfTicket),
    .moneyToPay    (moneyToPay),
    .totalMoney    (totalMoney)
`ifdef VM_CHANGE_EN
    ,
    .change        (change)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [6:0] c, input logic [6:0] d,
                           input logic [6:0] t);
    check_eq({tag, ".cost"}, costOfTicket, c);
    check_eq({tag, ".due"}, moneyToPay, d);
    check_eq({tag, ".total"}, totalMoney, t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int coins[6]   = '{10, 5, 1, 10, 10, 10};
  int totals[6]  = '{10, 15, 16, 26, 36, 46};

  initial begin
    reset         = 1'b1;
    howManyTicket = 3'd0;
    origin        = 3'd0;
    destination   = 3'd0;
    money         = 6'd0;
    do_reset();
    check_all("rst", 7'd0, 7'd0, 7'd0);
`ifdef VM_CHANGE_EN
    check_eq("rst.change", change, 7'd0);
`endif

    // Trip 2->6 accepted on first edge after reset release
    origin = 3'd2; destination = 3'd6;
    step();
    check_all("t1", 7'd25, 7'd0, 7'd0);

    // Full transaction 4->1, two tickets
    do_reset();
    origin = 3'd4; destination = 3'd1; howManyTicket = 3'd2;
    step();
    check_all("t2.sel", 7'd20, 7'd0, 7'd0);
    step();
    check_all("t2.qty", 7'd20, 7'd40, 7'd0);
    for (int i = 0; i < 6; i++) begin
      money = coins[i][5:0];
      step();
      check_eq($sformatf("t2.pay%0d", i), totalMoney, totals[i][6:0]);
`ifdef VM_CHANGE_EN
      check_eq($sformatf("t2.chg%0d", i), change, (i == 5) ? 7'd6 : 7'd0);
`endif
    end
    // DONE holds everything
    money = 6'd10; origin = 3'd1; destination = 3'd7; howManyTicket = 3'd3;
    step();
    step();
    check_all("t2.done", 7'd20, 7'd40, 7'd46);
`ifdef VM_CHANGE_EN
    check_eq("t2.done.change", change, 7'd6);
`endif

    // Invalid trips ignored, then 1->7
    do_reset();
    money = 6'd0; howManyTicket = 3'd0;
    origin = 3'd3; destination = 3'd3;
    step();
    step();
    check_eq("t3.same", costOfTicket, 7'd0);
    origin = 3'd0;
    step();
    check_eq("t3.zero", costOfTicket, 7'd0);
    origin = 3'd1; destination = 3'd7;
    step();
    check_eq("t3.valid", costOfTicket, 7'd35);

    // Invalid counts ignored in QTY; trip changes ignored too
    howManyTicket = 3'd5; origin = 3'd2; destination = 3'd3;
    step();
    check_all("t4.five", 7'd35, 7'd0, 7'd0);
    howManyTicket = 3'd0;
    step();
    check_eq("t4.zero", moneyToPay, 7'd0);

    // 7->1, three tickets
    do_reset();
    origin = 3'd7; destination = 3'd1; howManyTicket = 3'd3;
    step();
    check_eq("t5.cost", costOfTicket, 7'd35);
    step();
    check_eq("t5.due", moneyToPay, 7'd105);

    // Invalid coins add nothing; held coin counts each cycle
    money = 6'd7;
    step();
    check_eq("t6.c7", totalMoney, 7'd0);
    money = 6'd0;
    step();
    check_eq("t6.c0", totalMoney, 7'd0);
    money = 6'd50;
    step();
    check_eq("t6.c50", totalMoney, 7'd0);
    money = 6'd5;
    step();
    step();
    step();
    check_eq("t6.held", totalMoney, 7'd15);
`ifdef VM_CHANGE_EN
    check_eq("t6.change", change, 7'd0);
`endif

    // Asynchronous reset mid-payment
    #2;
    reset = 1'b1;
    #1;
    check_all("t7.async", 7'd0, 7'd0, 7'd0);
    step();
    reset = 1'b0;
    money = 6'd0; howManyTicket = 3'd0;
    origin = 3'd2; destination = 3'd6;
    step();
    check_all("t7.select", 7'd25, 7'd0, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
